turbo_duobin_enc: RTL and testbench

- Downstream neighbour of the interleaver top: consumes its natural-order and interleaved duo-binary symbol streams (rdata / rdata_itl / dout_vld).
- Runs two identical 8-state duo-binary recursive systematic convolutional (RSC) encoders, one per stream, zero-started.
- Emits systematic pairs plus punctured parity, and reports both final encoder states to the downstream circulation-state correction stage.

---
 rtl/turbo_duobin_enc_pkg.sv | 37 +++
 rtl/turbo_duobin_enc_rsc.sv | 38 +++
 rtl/turbo_duobin_enc.sv | 159 +++++++++++++++
 tb/tb_turbo_duobin_enc.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/turbo_duobin_enc_pkg.sv
// Shared constants for the duo-binary turbo encoder:
//   PB length table, pb_size codes, FSM state encoding, puncture masks,
//   and a helper that maps a pb_size code to its block length.
package turbo_duobin_enc_pkg;

  localparam int CNT_W = 12;

  localparam logic [CNT_W-1:0] PB_LEN16  = 12'd64;
  localparam logic [CNT_W-1:0] PB_LEN136 = 12'd544;
  localparam logic [CNT_W-1:0] PB_LEN520 = 12'd2080;

  localparam logic [1:0] PB_SZ_16  = 2'd0;
  localparam logic [1:0] PB_SZ_136 = 2'd1;
  localparam logic [1:0] PB_SZ_520 = 2'd2;
  localparam logic [1:0] PB_SZ_BAD = 2'd3;

  // par_keep bit order follows par_out = {p1, p2}
  localparam logic [1:0] KEEP_ALL = 2'b11;
  localparam logic [1:0] KEEP_P1  = 2'b10;
  localparam logic [1:0] KEEP_P2  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // Illegal code maps to the shortest length; ERR absorbs that many symbols.
  function automatic logic [CNT_W-1:0] pb_len(input logic [1:0] code);
    case (code)
      PB_SZ_136: pb_len = PB_LEN136;
      PB_SZ_520: pb_len = PB_LEN520;
      default:   pb_len = PB_LEN16;
    endcase
  endfunction

endpackage

// File: rtl/turbo_duobin_enc_rsc.sv
// 8-state duo-binary recursive systematic convolutional encoder slice.
//   clk, n_rst : clock, async active-low reset
//   en_i       : advance state with sym_i
//   clr_i      : synchronous clear (wins over en_i)
//   zero_i     : encode sym_i from state 0 instead of the held state
//   sym_i      : {A,B}
//   par_o      : parity of sym_i from the current state (combinational)
//   nxt_o      : post-update state {s1,s2,s3} (combinational)
module duobin_rsc (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       zero_i,
  input  logic [1:0] sym_i,
  output logic       par_o,
  output logic [2:0] nxt_o
);

  logic [2:0] state_q;
  logic [2:0] cur;
  logic       fb;

  // state bits: [2]=s1, [1]=s2, [0]=s3; sym bits: [1]=A, [0]=B
  always_comb begin
    cur   = zero_i ? 3'b000 : state_q;
    fb    = sym_i[1] ^ sym_i[0] ^ cur[1] ^ cur[0];
    par_o = fb ^ cur[2] ^ cur[0];
    nxt_o = {fb, cur[2] ^ sym_i[0], cur[1] ^ sym_i[0]};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      state_q <= 3'b000;
    else if (clr_i)  state_q <= 3'b000;
    else if (en_i)   state_q <= nxt_o;
  end

endmodule

// File: rtl/turbo_duobin_enc.sv
// Duo-binary turbo encoder: two zero-started RSC encoders (natural and
// interleaved streams), systematic pass-through, punctured parity mask,
// final-state report for circulation-state correction.
//   clk, n_rst        : clock, async active-low reset
//   pb_size, rate_sel : block config, sampled on a block's first symbol
//   din, din_itl      : natural / interleaved {A,B}; din_vld qualifies both
//   sys_out, par_out  : registered systematic symbol and {p1,p2}
//   par_keep          : puncture mask for par_out (1 = transmit)
//   dout_vld          : output valid, 1 cycle after din_vld
//   blk_done          : pulse with the last symbol's dout_vld
//   fstate1, fstate2  : final encoder states, valid with blk_done
//   size_err          : pulse when a block starts with pb_size=3
module turbo_duobin_enc
  import turbo_duobin_enc_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] pb_size,
  input  logic       rate_sel,
  input  logic [1:0] din,
  input  logic [1:0] din_itl,
  input  logic       din_vld,
  output logic [1:0] sys_out,
  output logic [1:0] par_out,
  output logic [1:0] par_keep,
  output logic       dout_vld,
  output logic       blk_done,
  output logic [2:0] fstate1,
  output logic [2:0] fstate2,
  output logic       size_err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             rate_q, rate_d;

  logic             start, enc_en, last, err_start;
  logic [CNT_W-1:0] k, len;
  logic             rate;
  logic [1:0]       keep;

  // index 0 = natural stream, 1 = interleaved stream
  logic [1:0][1:0]  sym;
  logic [1:0]       par;
  logic [1:0][2:0]  nxt;

  assign sym = {din_itl, din};

  for (genvar g = 0; g < 2; g++) begin : g_enc
    duobin_rsc u_rsc (
      .clk    (clk),
      .n_rst  (n_rst),
      .en_i   (enc_en),
      .clr_i  (last),
      .zero_i (start),
      .sym_i  (sym[g]),
      .par_o  (par[g]),
      .nxt_o  (nxt[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    rate_d    = rate_q;
    start     = 1'b0;
    enc_en    = 1'b0;
    err_start = 1'b0;
    k         = cnt_q;
    len       = len_q;
    rate      = rate_q;

    case (state_q)
      ST_IDLE: begin
        if (din_vld) begin
          len_d = pb_len(pb_size);
          if (pb_size == PB_SZ_BAD) begin
            err_start = 1'b1;
            state_d   = ST_ERR;
            cnt_d     = 12'd1;
          end else begin
            // first symbol uses the live config, not the latched one
            start  = 1'b1;
            enc_en = 1'b1;
            rate_d = rate_sel;
            k      = '0;
            len    = pb_len(pb_size);
            rate   = rate_sel;
          end
        end
      end
      ST_RUN: begin
        if (din_vld) enc_en = 1'b1;
      end
      ST_ERR: begin
        if (din_vld) begin
          if (cnt_q == PB_LEN16 - 12'd1) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    last = enc_en && (k == len - 12'd1);

    if (enc_en) begin
      if (last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ST_RUN;
        cnt_d   = k + 12'd1;
      end
    end

    keep = rate ? (k[0] ? KEEP_P2 : KEEP_P1) : KEEP_ALL;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      rate_q   <= 1'b0;
      sys_out  <= '0;
      par_out  <= '0;
      par_keep <= '0;
      dout_vld <= 1'b0;
      blk_done <= 1'b0;
      fstate1  <= '0;
      fstate2  <= '0;
      size_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      rate_q   <= rate_d;
      dout_vld <= enc_en;
      blk_done <= last;
      size_err <= err_start;
      if (enc_en) begin
        sys_out  <= din;
        par_out  <= {par[0], par[1]};
        par_keep <= keep;
      end
      if (last) begin
        fstate1 <= nxt[0];
        fstate2 <= nxt[1];
      end
    end
  end

endmodule

// File: tb/tb_turbo_duobin_enc.sv
module tb_turbo_duobin_enc;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [1:0] pb_size;
  logic       rate_sel;
  logic [1:0] din, din_itl;
  logic       din_vld;
  logic [1:0] sys_out, par_out, par_keep;
  logic       dout_vld, blk_done, size_err;
  logic [2:0] fstate1, fstate2;

  turbo_duobin_enc dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .pb_size  (pb_size),
    .rate_sel (rate_sel),
    .din      (din),
    .din_itl  (din_itl),
    .din_vld  (din_vld),
    .sys_out  (sys_out),
    .par_out  (par_out),
    .par_keep (par_keep),
    .dout_vld (dout_vld),
    .blk_done (blk_done),
    .fstate1  (fstate1),
    .fstate2  (fstate2),
    .size_err (size_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // spec-level reference: mode 0 idle, 1 run, 2 err
  int         mmode = 0, mcnt = 0, mlen = 0;
  logic       mrate = 1'b0;
  logic [2:0] ms1 = '0, ms2 = '0;

  int         n_vld = 0, n_done = 0, n_err = 0, last_done_vld = 0, done_gap = 0;
  logic [1:0] obs_par, obs_keep;
  logic [2:0] obs_fs1, obs_fs2;

  // returns {parity, next_state}; state = {s1,s2,s3}, ab = {A,B}
  function automatic logic [3:0] rsc(input logic [2:0] s, input logic [1:0] ab);
    logic a, b, s1, s2, s3, fb;
    a = ab[1]; b = ab[0]; s1 = s[2]; s2 = s[1]; s3 = s[0];
    fb = a ^ b ^ s2 ^ s3;
    return {fb ^ s1 ^ s3, fb, s1 ^ b, s2 ^ b};
  endfunction

  task automatic drive(input logic [1:0] d, input logic [1:0] di, input logic v,
                       input logic [1:0] pb, input logic rs);
    logic [3:0] r1, r2;
    logic       enc, edone, eerr;
    logic [1:0] epar, ekeep;
    logic [2:0] efs1, efs2;
    enc = 0; edone = 0; eerr = 0; epar = '0; ekeep = '0; efs1 = '0; efs2 = '0;
    din = d; din_itl = di; din_vld = v; pb_size = pb; rate_sel = rs;
    if (v) begin
      case (mmode)
        0: if (pb == 2'd3) begin
             eerr = 1; mmode = 2; mcnt = 1;
           end else begin
             mlen = (pb == 2'd0) ? 64 : (pb == 2'd1) ? 544 : 2080;
             mrate = rs; ms1 = '0; ms2 = '0; mcnt = 0; mmode = 1; enc = 1;
           end
        1: enc = 1;
        default: if (mcnt == 63) begin mmode = 0; mcnt = 0; end else mcnt++;
      endcase
    end
    if (enc) begin
      r1 = rsc(ms1, d); r2 = rsc(ms2, di);
      epar  = {r1[3], r2[3]};
      ekeep = !mrate ? 2'b11 : (mcnt % 2 == 1) ? 2'b01 : 2'b10;
      ms1 = r1[2:0]; ms2 = r2[2:0];
      edone = (mcnt == mlen - 1);
      if (edone) begin
        efs1 = ms1; efs2 = ms2; ms1 = '0; ms2 = '0; mmode = 0; mcnt = 0;
      end else mcnt++;
    end
    @(posedge clk); #1;
    chk("dout_vld", dout_vld, enc);
    chk("blk_done", blk_done, edone);
    chk("size_err", size_err, eerr);
    if (enc) begin
      chk("sys_out", sys_out, d);
      chk("par_out", par_out, epar);
      chk("par_keep", par_keep, ekeep);
    end
    if (edone) begin
      chk("fstate1", fstate1, efs1);
      chk("fstate2", fstate2, efs2);
    end
    obs_par = par_out; obs_keep = par_keep;
    if (dout_vld) n_vld++;
    if (size_err) n_err++;
    if (blk_done) begin
      n_done++; obs_fs1 = fstate1; obs_fs2 = fstate2;
      done_gap = n_vld - last_done_vld; last_done_vld = n_vld;
    end
  endtask

  task automatic rnd_block(input logic [1:0] pb, input logic rs, input int len);
    for (int i = 0; i < len; i++)
      drive(2'($urandom), 2'($urandom), 1'b1, pb, rs);
  endtask

  initial begin
    int v0, d0;
    n_rst = 1'b0; din = '0; din_itl = '0; din_vld = 1'b0; pb_size = '0; rate_sel = 1'b0;
    #12;
    chk("rst dout_vld", dout_vld, 0);
    chk("rst par_out", par_out, 0);
    chk("rst fstate1", fstate1, 0);
    chk("rst size_err", size_err, 0);
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;

    // 1: hand-computed block, 10,00,00 then zeros -> final state 100
    v0 = n_vld; d0 = n_done;
    drive(2'b10, 2'b10, 1, 2'd0, 0); chk("t1 par0", obs_par, 2'b11); chk("t1 keep0", obs_keep, 2'b11);
    drive(2'b00, 2'b00, 1, 2'd0, 0); chk("t1 par1", obs_par, 2'b11);
    drive(2'b00, 2'b00, 1, 2'd0, 0); chk("t1 par2", obs_par, 2'b11);
    for (int i = 0; i < 61; i++) drive(2'b00, 2'b00, 1, 2'd0, 0);
    chk("t1 done cnt", n_done - d0, 1);
    chk("t1 done idx", last_done_vld - v0, 64);
    chk("t1 fs1", obs_fs1, 3'b100);
    chk("t1 fs2", obs_fs2, 3'b100);
    drive(0, 0, 0, 0, 0);

    // 2: 544 random symbols at rate 1/2, config changes mid-block ignored
    v0 = n_vld; d0 = n_done;
    drive(2'($urandom), 2'($urandom), 1, 2'd1, 1); chk("t2 keep0", obs_keep, 2'b10);
    drive(2'($urandom), 2'($urandom), 1, 2'd0, 0); chk("t2 keep1", obs_keep, 2'b01);
    rnd_block(2'd2, 0, 542);
    chk("t2 vld cnt", n_vld - v0, 544);
    chk("t2 done cnt", n_done - d0, 1);

    // 3: 2080 symbols with ~30% idle gaps
    v0 = n_vld; d0 = n_done;
    for (int sent = 0; sent < 2080; ) begin
      if ($urandom_range(0, 9) < 3) drive(2'($urandom), 2'($urandom), 0, 2'd2, 0);
      else begin drive(2'($urandom), 2'($urandom), 1, 2'd2, 0); sent++; end
    end
    chk("t3 vld cnt", n_vld - v0, 2080);
    chk("t3 done cnt", n_done - d0, 1);

    // 4: back-to-back pb16 blocks, no idle cycle
    d0 = n_done;
    rnd_block(2'd0, 0, 64);
    drive(2'b10, 2'b10, 1, 2'd0, 0); chk("t4 first par", obs_par, 2'b11);
    rnd_block(2'd0, 0, 63);
    chk("t4 done cnt", n_done - d0, 2);
    chk("t4 done gap", done_gap, 64);

    // 5: reset at symbol 300 of a 544 block
    rnd_block(2'd1, 1, 300);
    n_rst = 1'b0; din_vld = 1'b0; #1;
    chk("t5 rst dout_vld", dout_vld, 0);
    chk("t5 rst sys_out", sys_out, 0);
    chk("t5 rst par_out", par_out, 0);
    chk("t5 rst par_keep", par_keep, 0);
    mmode = 0; mcnt = 0; ms1 = '0; ms2 = '0;
    #2 n_rst = 1'b1;
    @(posedge clk); #1;
    v0 = n_vld; d0 = n_done;
    rnd_block(2'd0, 0, 64);
    chk("t5 vld cnt", n_vld - v0, 64);
    chk("t5 done cnt", n_done - d0, 1);

    // 6: illegal size absorbs 64 symbols, then a normal block
    v0 = n_vld; d0 = n_err;
    drive(2'b11, 2'b01, 1, 2'd3, 0);
    rnd_block(2'd0, 0, 63);
    chk("t6 err cnt", n_err - d0, 1);
    chk("t6 absorbed", n_vld - v0, 0);
    d0 = n_done;
    rnd_block(2'd0, 1, 64);
    chk("t6 vld cnt", n_vld - v0, 64);
    chk("t6 done cnt", n_done - d0, 1);

    drive(0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
